skew_inbuf: RTL and testbench
=============================

# skew_inbuf

Multi-lane circular input buffer that feeds one edge of the PE array. Each lane is a FIFO. On reset or flush, lane i is preloaded with i×PAD_STEP zero words, so a single vector write produces the diagonal skew the systolic array needs. Unlike the single-lane buffer it replaces, it guards against overflow and underflow, reports occupancy, supports a drain mode that empties the skew tail, and accepts any depth, not only powers of two.

## Interface
- WORDLEN, 8, data bits per lane word
- LANES, 4, number of lanes (array rows or columns)
- DEPTH, 16, words per lane; any value from 2 to 64; must satisfy DEPTH > (LANES-1)×PAD_STEP
- PAD_STEP, 1, zero words added per lane index at reset/flush
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous re-initialisation to the reset state
- wr  in  1  push request; din is written to all lanes
- din  in  LANES×WORDLEN  lane i occupies bits [i×WORDLEN +: WORDLEN]
- rd  in  1  pop request for all lanes
- drain  in  1  while high, rd is also accepted when lane 0 is empty
- wr_accept  out  1  combinational; push is taking effect this cycle
- rd_accept  out  1  combinational; pop is taking effect this cycle
- empty  out  1  lane 0 occupancy == 0
- full  out  1  lane LANES-1 occupancy == DEPTH
- level  out  $clog2(DEPTH+1)  lane 0 occupancy
- dout  out  LANES×WORDLEN  head word of each lane; 0 for an empty lane

## Operation
- Per lane: storage, head and tail pointers, and an occupancy count cnt[i]. Pointers wrap from DEPTH-1 to 0.
- All lanes are written together and popped together, so cnt[0] is always the minimum and cnt[LANES-1] the maximum. empty and full are derived from those two lanes only.
- rd_accept = rd & (!empty | drain).
  - On an accepted pop, each lane with cnt[i] > 0 advances head and decrements its count.
  - Lanes with cnt[i] == 0 are left unchanged.
- wr_accept = wr & (!full | rd_accept).
  - On an accepted push, every lane writes its slice of din at tail, advances tail and increments its count.
- Simultaneous accepted pop and push: counts net to unchanged, except in drain mode a lane that was empty ends with cnt 1.
- Rejected requests have no effect on any state.
- Reset and flush state:
  - lane i storage holds zeros;
  - head = 0, tail = cnt[i] = i×PAD_STEP.
- flush takes priority over rd and wr in the same cycle. rstn takes priority over everything.
- dout is first-word-fall-through: a combinational read of mem[head], forced to 0 when cnt[i] == 0.

## Timing
- Reset values: empty=1, full=0, level=0, dout=0, wr_accept=0, rd_accept=0 (the accept outputs stay 0 while wr and rd are low).
- Write latency: a word pushed in cycle N appears on dout in cycle N+1 if it is at the head.
- A pop in cycle N shows the next word on dout in cycle N+1.
- A pushed vector exits lane i exactly i×PAD_STEP pops after it exits lane 0.
- A full-rate stream sustains one push and one pop per cycle with no bubbles.
- flush or rstn asserted mid-stream discards all data in the same edge. Nothing is retained.

## Configuration
- SKEW_INBUF_ERR_EN defined:
  - adds sticky outputs ovf_err (wr while full and no rd_accept) and udf_err (rd while empty and drain low);
  - both are registered, set one cycle after the event, and cleared only by rstn or flush.
- Macro undefined: these ports and their logic are absent. Rejected requests are silently dropped.

## Structure
- Shared package systola_pkg holds:
  - ptr_w(depth) and cnt_w(depth) width functions;
  - a default WORDLEN constant;
  - the lane_word_t typedef.
- Natural sub-module: skew_lane_fifo, one lane with storage, pointers and count.
  - Parameter PRELOAD sets its reset occupancy.
  - Its inputs are the common push and pop enables, so lanes never diverge.
- The top level generates LANES instances and computes accept, empty and full.

## Test plan
- Reset with LANES=4, PAD_STEP=1, DEPTH=8 → empty=1, full=0, level=0, dout=0. Internal cnt = {0,1,2,3}.
- Push 0x11, 0x22, 0x33 then pop continuously → lane0 outputs 11,22,33. Lane3 outputs 0,0,0,11,22,33, the last three only with drain=1.
- Push 5 words with no pops → full=1 (lane3 cnt=8). A 6th push gives wr_accept=0 and contents unchanged. With SKEW_INBUF_ERR_EN, ovf_err=1 next cycle.
- At full, push 0xAA with a simultaneous pop → both accepted, full stays 1, 0xAA lands at lane0 tail.
- DEPTH=6 (non-power-of-two), 20 push/pop pairs → pointers wrap at 5→0 and output order is preserved.
- Flush with wr=1 in the same cycle → wr ignored and the buffer returns to the reset counts {0,1,2,3}.

Source files
------------

// File: rtl/systola_pkg.sv
// Shared types and width helpers for the systolic-array feed path.
package systola_pkg;

   localparam int unsigned WORDLEN_DEF = 8;

   typedef logic [WORDLEN_DEF-1:0] lane_word_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/skew_inbuf_if.sv
// Push/pop handshake and status bundle for skew_inbuf.
// Optional SKEW_INBUF_ERR_EN adds the sticky ovf_err/udf_err flags.
interface skew_inbuf_if import systola_pkg::*; #(
   parameter int unsigned WORDLEN = WORDLEN_DEF,
   parameter int unsigned LANES   = 4,
   parameter int unsigned DEPTH   = 16
);
   logic                          flush;
   logic                          wr;
   logic                          rd;
   logic                          drain;
   logic [LANES*WORDLEN-1:0]      din;
   logic                          wr_accept;
   logic                          rd_accept;
   logic                          empty;
   logic                          full;
   logic [cnt_w(DEPTH)-1:0]       level;
   logic [LANES*WORDLEN-1:0]      dout;
`ifdef SKEW_INBUF_ERR_EN
   logic                          ovf_err;
   logic                          udf_err;

   modport master (
      output flush, wr, rd, drain, din,
      input  wr_accept, rd_accept, empty, full, level, dout, ovf_err, udf_err
   );
   modport slave (
      input  flush, wr, rd, drain, din,
      output wr_accept, rd_accept, empty, full, level, dout, ovf_err, udf_err
   );
`else
   modport master (
      output flush, wr, rd, drain, din,
      input  wr_accept, rd_accept, empty, full, level, dout
   );
   modport slave (
      input  flush, wr, rd, drain, din,
      output wr_accept, rd_accept, empty, full, level, dout
   );
`endif
endinterface

// File: rtl/skew_lane_fifo.sv
// One lane of the skew buffer: circular storage with FWFT head and an
// occupancy count that starts at PRELOAD zero words.
module skew_lane_fifo import systola_pkg::*; #(
   parameter int unsigned WORDLEN = WORDLEN_DEF,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned PRELOAD = 0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WORDLEN-1:0]      din,
   output logic [WORDLEN-1:0]      dout,
   output logic [cnt_w(DEPTH)-1:0] cnt
);
   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [WORDLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A pop on an empty lane (drain mode) leaves that lane untouched.
   always_comb begin
      do_pop = pop && (cnt_q != '0);
      head_d = do_pop ? nxt(head_q) : head_q;
      tail_d = push ? nxt(tail_q) : tail_q;
      cnt_d  = cnt_q;
      if (push && !do_pop)
         cnt_d = cnt_q + 1'b1;
      else if (!push && do_pop)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         head_q <= '0;
         tail_q <= PW'(PRELOAD);
         cnt_q  <= CW'(PRELOAD);
      end else begin
         if (push)
            mem_q[tail_q] <= din;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout = (cnt_q == '0) ? '0 : mem_q[head_q];
   assign cnt  = cnt_q;

endmodule

// File: rtl/skew_inbuf.sv
// Multi-lane skewed input buffer: lane i starts with i*PAD_STEP zero words.
// Define SKEW_INBUF_ERR_EN to add sticky ovf_err/udf_err outputs.
module skew_inbuf import systola_pkg::*; #(
   parameter int unsigned WORDLEN  = WORDLEN_DEF,
   parameter int unsigned LANES    = 4,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned PAD_STEP = 1
) (
   input  logic        clk,
   input  logic        rstn,
   skew_inbuf_if.slave bus
);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [CW-1:0]      cnt      [LANES];
   logic [WORDLEN-1:0] lane_out [LANES];
   logic               empty, full, push, pop;

   // Lanes move in lockstep, so lane 0 is the minimum and the last lane the maximum.
   assign empty = (cnt[0] == '0);
   assign full  = (cnt[LANES-1] == CW'(DEPTH));
   assign pop   = rstn && !bus.flush && bus.rd && (!empty || bus.drain);
   assign push  = rstn && !bus.flush && bus.wr && (!full || pop);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      skew_lane_fifo #(
         .WORDLEN (WORDLEN),
         .DEPTH   (DEPTH),
         .PRELOAD (i * PAD_STEP)
      ) u_lane (
         .clk   (clk),
         .rstn  (rstn),
         .flush (bus.flush),
         .push  (push),
         .pop   (pop),
         .din   (bus.din[i*WORDLEN +: WORDLEN]),
         .dout  (lane_out[i]),
         .cnt   (cnt[i])
      );
   end

   always_comb begin
      bus.dout = '0;
      for (int unsigned i = 0; i < LANES; i++)
         bus.dout[i*WORDLEN +: WORDLEN] = lane_out[i];
   end

   assign bus.wr_accept = push;
   assign bus.rd_accept = pop;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.level     = cnt[0];

`ifdef SKEW_INBUF_ERR_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk) begin
      if (!rstn || bus.flush) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (bus.wr && full && !pop)
            ovf_q <= 1'b1;
         if (bus.rd && empty && !bus.drain)
            udf_q <= 1'b1;
      end
   end

   assign bus.ovf_err = ovf_q;
   assign bus.udf_err = udf_q;
`endif

endmodule

// File: tb/tb_skew_inbuf.sv
// Scoreboard bench for skew_inbuf: DEPTH=8 and DEPTH=6 instances, LANES=4, PAD_STEP=1.
module tb_skew_inbuf;
   import systola_pkg::*;

   logic clk;
   logic rstn;

   skew_inbuf_if #(.WORDLEN(8), .LANES(4), .DEPTH(8)) ia ();
   skew_inbuf_if #(.WORDLEN(8), .LANES(4), .DEPTH(6)) ib ();

   skew_inbuf #(.WORDLEN(8), .LANES(4), .DEPTH(8), .PAD_STEP(1)) dut_a (
      .clk (clk), .rstn (rstn), .bus (ia.slave)
   );
   skew_inbuf #(.WORDLEN(8), .LANES(4), .DEPTH(6), .PAD_STEP(1)) dut_b (
      .clk (clk), .rstn (rstn), .bus (ib.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned total  = 0;
   int unsigned passed = 0;

   // Words pushed since the last flush/reset and pops accepted, per instance.
   lane_word_t  S [2][64];
   int          n [2];
   int          p [2];
   logic [31:0] qa [$];
   logic [31:0] qb [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] mkvec(input lane_word_t b);
      return {b + 8'hC0, b + 8'h80, b + 8'h40, b};
   endfunction

   // Lane i has i zero pads ahead of the stream; empty lanes read as 0.
   function automatic logic [31:0] exp_vec(input int sel, input int pop_idx);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) begin
         int k;
         k = pop_idx - i;
         if (k >= 0 && k < n[sel])
            v[i*8 +: 8] = S[sel][k] + 8'(i * 64);
      end
      return v;
   endfunction

   task automatic drive(input int sel, input logic w, input logic r, input logic dr,
                        input logic fl, input lane_word_t base,
                        input logic ew, input logic er);
      logic wa, ra;
      @(posedge clk);
      #1;
      if (sel == 0) begin
         ia.wr = w; ia.rd = r; ia.drain = dr; ia.flush = fl; ia.din = mkvec(base);
      end else begin
         ib.wr = w; ib.rd = r; ib.drain = dr; ib.flush = fl; ib.din = mkvec(base);
      end
      #1;
      wa = (sel == 0) ? ia.wr_accept : ib.wr_accept;
      ra = (sel == 0) ? ia.rd_accept : ib.rd_accept;
      if (!fl) begin
         chk($sformatf("wr_accept[%0d]", sel), 32'(wa), 32'(ew));
         chk($sformatf("rd_accept[%0d]", sel), 32'(ra), 32'(er));
      end
      if (er) begin
         if (sel == 0) qa.push_back(exp_vec(0, p[0]));
         else          qb.push_back(exp_vec(1, p[1]));
         p[sel]++;
      end
      if (ew) begin
         S[sel][n[sel]] = base;
         n[sel]++;
      end
      if (fl) begin
         n[sel] = 0;
         p[sel] = 0;
      end
   endtask

   task automatic status(input int sel, input logic ee, input logic ef,
                         input int el, input logic [31:0] ed);
      drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (sel == 0) begin
         chk("empty[0]", 32'(ia.empty), 32'(ee));
         chk("full[0]",  32'(ia.full),  32'(ef));
         chk("level[0]", 32'(ia.level), 32'(el));
         chk("dout[0]",  ia.dout,       ed);
      end else begin
         chk("empty[1]", 32'(ib.empty), 32'(ee));
         chk("full[1]",  32'(ib.full),  32'(ef));
         chk("level[1]", 32'(ib.level), 32'(el));
         chk("dout[1]",  ib.dout,       ed);
      end
   endtask

   always @(negedge clk) begin
      if (ia.rd_accept === 1'b1) begin
         if (qa.size() == 0) begin
            total++;
            $display("FAIL pop_a: got unexpected pop expected none");
         end else chk("pop_dout_a", ia.dout, qa.pop_front());
      end
      if (ib.rd_accept === 1'b1) begin
         if (qb.size() == 0) begin
            total++;
            $display("FAIL pop_b: got unexpected pop expected none");
         end else chk("pop_dout_b", ib.dout, qb.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      ia.wr = 0; ia.rd = 0; ia.drain = 0; ia.flush = 0; ia.din = '0;
      ib.wr = 0; ib.rd = 0; ib.drain = 0; ib.flush = 0; ib.din = '0;
      n[0] = 0; n[1] = 0; p[0] = 0; p[1] = 0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Reset state
      status(0, 1'b1, 1'b0, 0, 32'h0);
      status(1, 1'b1, 1'b0, 0, 32'h0);
`ifdef SKEW_INBUF_ERR_EN
      chk("ovf_rst", 32'(ia.ovf_err), 32'd0);
      chk("udf_rst", 32'(ia.udf_err), 32'd0);
`endif

      // Three words, then pops; lane 0 drains first, tail needs drain
      drive(0, 1, 0, 0, 0, 8'h11, 1, 0);
      drive(0, 1, 0, 0, 0, 8'h22, 1, 0);
      drive(0, 1, 0, 0, 0, 8'h33, 1, 0);
      status(0, 1'b0, 1'b0, 3, 32'h0000_0011);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 8'h00, 0, 1);
      drive(0, 0, 1, 0, 0, 8'h00, 0, 0);
`ifdef SKEW_INBUF_ERR_EN
      status(0, 1'b1, 1'b0, 0, 32'h1133_0000 ^ 32'h1133_0000 ^ exp_vec(0, p[0]));
      chk("udf_set", 32'(ia.udf_err), 32'd1);
`endif
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 8'h00, 0, 1);
      status(0, 1'b1, 1'b0, 0, 32'h0);

      // Flush with a concurrent write: write is dropped, pads return
      drive(0, 1, 0, 0, 1, 8'h99, 0, 0);
      status(0, 1'b1, 1'b0, 0, 32'h0);
`ifdef SKEW_INBUF_ERR_EN
      chk("udf_flush", 32'(ia.udf_err), 32'd0);
`endif
      drive(0, 1, 0, 0, 0, 8'h5A, 1, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0, 8'h00, 0, 1);
      status(0, 1'b1, 1'b0, 0, 32'h0);
      drive(0, 0, 0, 0, 1, 8'h00, 0, 0);

      // Fill to full, then one rejected push
      for (int i = 1; i <= 5; i++) drive(0, 1, 0, 0, 0, 8'(i), 1, 0);
      status(0, 1'b0, 1'b1, 5, 32'h0000_0001);
      drive(0, 1, 0, 0, 0, 8'h77, 0, 0);
      status(0, 1'b0, 1'b1, 5, 32'h0000_0001);
`ifdef SKEW_INBUF_ERR_EN
      chk("ovf_set", 32'(ia.ovf_err), 32'd1);
`endif

      // Push+pop at full, then drain everything out
      drive(0, 1, 1, 0, 0, 8'hAA, 1, 1);
      status(0, 1'b0, 1'b1, 5, 32'h0000_4102);
      for (int i = 0; i < 8; i++) drive(0, 0, 1, 1, 0, 8'h00, 0, 1);
      status(0, 1'b1, 1'b0, 0, 32'h0);

      // DEPTH=6: full-rate stream across pointer wrap
      drive(1, 1, 0, 0, 0, 8'h01, 1, 0);
      for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 0, 8'(i + 2), 1, 1);
      status(1, 1'b0, 1'b0, 1, exp_vec(1, p[1]));
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 1, 0, 8'h00, 0, 1);
      status(1, 1'b1, 1'b0, 0, 32'h0);

      chk("queue_a_drained", 32'(qa.size()), 32'd0);
      chk("queue_b_drained", 32'(qb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
